// File: rtl/maxnet_iter_ctrl.sv
// maxnet_iter_ctrl: drives four PLUs through multiply/add/ReLU passes and feeds
// the ReLU results back until one activation survives, none do, or MAX_ITER passes elapse.
module maxnet_iter_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 64,
    parameter int CW       = $clog2(MAX_ITER + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_init1,
    input  logic [WIDTH-1:0] a_init2,
    input  logic [WIDTH-1:0] a_init3,
    input  logic [WIDTH-1:0] a_init4,
    input  logic [WIDTH-1:0] plu_out1,
    input  logic [WIDTH-1:0] plu_out2,
    input  logic [WIDTH-1:0] plu_out3,
    input  logic [WIDTH-1:0] plu_out4,
    output logic [WIDTH-1:0] act1,
    output logic [WIDTH-1:0] act2,
    output logic [WIDTH-1:0] act3,
    output logic [WIDTH-1:0] act4,
    output logic             w_we,
    output logic             a_we,
    output logic             r1_we,
    output logic             r2_we,
    output logic             r3_we,
    output logic             done,
    output logic             found,
    output logic             timeout,
    output logic [1:0]       winner,
    output logic [CW-1:0]    iter_count
);
    typedef enum logic [2:0] {IDLE, LOAD, MUL, ADD, RELU, CAPTURE, CHECK, DONE} state_t;
    state_t state, state_nx;
    logic first;
    logic [3:0] pos;
    logic [2:0] npos;
    logic [1:0] pidx;
    logic at_limit;
    logic restart;

    // Positive means sign bit clear and value non-zero.
    assign pos = {~act4[WIDTH-1] & |act4, ~act3[WIDTH-1] & |act3,
                  ~act2[WIDTH-1] & |act2, ~act1[WIDTH-1] & |act1};
    assign npos = 3'(pos[0]) + 3'(pos[1]) + 3'(pos[2]) + 3'(pos[3]);
    assign pidx = pos[0] ? 2'd0 : pos[1] ? 2'd1 : pos[2] ? 2'd2 : 2'd3;
    assign at_limit = iter_count == CW'(MAX_ITER);
    assign restart = (state == IDLE || state == DONE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        w_we = 1'b0;
        a_we = 1'b0;
        r1_we = 1'b0;
        r2_we = 1'b0;
        r3_we = 1'b0;
        done = 1'b0;
        case (state)
            IDLE:    state_nx = start ? LOAD : IDLE;
            LOAD:    begin a_we = 1'b1; w_we = first; state_nx = MUL; end
            MUL:     begin r1_we = 1'b1; state_nx = ADD; end
            ADD:     begin r2_we = 1'b1; state_nx = RELU; end
            RELU:    begin r3_we = 1'b1; state_nx = CAPTURE; end
            CAPTURE: state_nx = CHECK;
            CHECK:   state_nx = (npos <= 3'd1 || at_limit) ? DONE : LOAD;
            DONE:    begin done = 1'b1; state_nx = start ? LOAD : DONE; end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act1 <= '0;
            act2 <= '0;
            act3 <= '0;
            act4 <= '0;
            found <= 1'b0;
            timeout <= 1'b0;
            winner <= '0;
            iter_count <= '0;
            first <= 1'b0;
        end else begin
            if (restart) begin
                act1 <= a_init1;
                act2 <= a_init2;
                act3 <= a_init3;
                act4 <= a_init4;
                found <= 1'b0;
                timeout <= 1'b0;
                winner <= '0;
                iter_count <= '0;
                first <= 1'b1;
            end
            // Weights only need loading once per competition.
            if (state == LOAD) first <= 1'b0;
            if (state == CAPTURE) begin
                act1 <= plu_out1;
                act2 <= plu_out2;
                act3 <= plu_out3;
                act4 <= plu_out4;
                iter_count <= iter_count + CW'(1);
            end
            if (state == CHECK) begin
                if (npos == 3'd1) begin
                    found <= 1'b1;
                    winner <= pidx;
                end else if (npos != 3'd0 && at_limit) timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// tb_maxnet_iter_ctrl: drives competitions through scripted PLU pipelines and checks
// enables, schedule and results against an iteration-level reference model.
module tb_maxnet_iter_ctrl;
    localparam int WIDTH = 32;
    localparam int MAX_ITER = 4;
    localparam int CW = $clog2(MAX_ITER + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [127:0] init_v = '0;
    logic [127:0] plu_v = '0;
    wire [127:0] act_v;
    logic w_we, a_we, r1_we, r2_we, r3_we, done, found, timeout;
    logic [1:0] winner;
    logic [CW-1:0] iter_count;
    int checks = 0;
    int errors = 0;

    logic [127:0] scr[$];
    logic [127:0] pq[$];
    logic [127:0] r1, r2;
    wire [5:0] ctl = {w_we, a_we, r1_we, r2_we, r3_we, done};
    wire [127+6+2+2+CW:0] all_out = {act_v, ctl, found, timeout, winner, iter_count};

    always #5 clk = ~clk;

    maxnet_iter_ctrl #(.WIDTH(WIDTH), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_init1(init_v[31:0]), .a_init2(init_v[63:32]),
        .a_init3(init_v[95:64]), .a_init4(init_v[127:96]),
        .plu_out1(plu_v[31:0]), .plu_out2(plu_v[63:32]),
        .plu_out3(plu_v[95:64]), .plu_out4(plu_v[127:96]),
        .act1(act_v[31:0]), .act2(act_v[63:32]),
        .act3(act_v[95:64]), .act4(act_v[127:96]),
        .w_we(w_we), .a_we(a_we), .r1_we(r1_we), .r2_we(r2_we), .r3_we(r3_we),
        .done(done), .found(found), .timeout(timeout), .winner(winner),
        .iter_count(iter_count)
    );

    // PLU stand-in: scripted result enters at r1 and walks r1->r2->r3; last entry repeats.
    always @(posedge clk) begin
        if (r1_we) begin
            r1 <= pq[0];
            if (pq.size() > 1) void'(pq.pop_front());
        end
        if (r2_we) r2 <= r1;
        if (r3_we) plu_v <= r2;
    end

    function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [31:0] rnd_val();
        int s = int'($urandom_range(0, 3));
        if (s == 1) return 32'($urandom_range(1, 100));
        if (s == 2) return 32'(-int'($urandom_range(1, 100)));
        return 32'd0;
    endfunction

    task automatic run_comp(input logic [127:0] init, input int pulse_c, input string nm);
        logic [127:0] seq[$];
        logic [127:0] a;
        logic [5:0] exp;
        int n = 0;
        int cnt;
        int w = 0;
        int done_c = 0;
        int p;
        bit f = 0;
        bit to = 0;
        seq.push_back(init);
        for (int k = 1; k <= MAX_ITER; k++) begin
            a = scr[(k - 1 < scr.size()) ? k - 1 : scr.size() - 1];
            cnt = 0;
            for (int i = 0; i < 4; i++)
                if ($signed(a[i*32 +: 32]) > 0) begin cnt++; w = i; end
            seq.push_back(a);
            n = k;
            if (cnt == 1) begin f = 1; break; end
            if (cnt == 0) break;
            if (k == MAX_ITER) to = 1;
        end
        pq = scr;
        @(negedge clk);
        init_v = init;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 6 * MAX_ITER + 3 && done_c == 0; c++) begin
            @(negedge clk);
            start = (c == pulse_c);
            p = (c - 1) % 6;
            exp = (c <= 6 * n) ? {p == 0 && c == 1, p == 0, p == 1, p == 2, p == 3, 1'b0} : 6'b000001;
            checks++;
            if (ctl !== exp) begin
                errors++;
                $display("FAIL %s enables cycle %0d: got %b want %b", nm, c, ctl, exp);
            end
            if (p == 0 && c <= 6 * n) begin
                checks++;
                if (act_v !== seq[(c - 1) / 6]) begin
                    errors++;
                    $display("FAIL %s act in LOAD cycle %0d: got %h want %h", nm, c, act_v, seq[(c - 1) / 6]);
                end
            end
            if (done === 1'b1) done_c = c;
        end
        start = 1'b0;
        checks++;
        if (done_c != 6 * n + 1) begin
            errors++;
            $display("FAIL %s done cycle: got %0d want %0d", nm, done_c, 6 * n + 1);
        end
        checks++;
        if ({found, timeout} !== {f, to}) begin
            errors++;
            $display("FAIL %s found/timeout: got %b%b want %b%b", nm, found, timeout, f, to);
        end
        checks++;
        if (winner !== (f ? 2'(w) : 2'd0)) begin
            errors++;
            $display("FAIL %s winner: got %0d want %0d", nm, winner, f ? w : 0);
        end
        checks++;
        if (iter_count !== CW'(n)) begin
            errors++;
            $display("FAIL %s iter_count: got %0d want %0d", nm, iter_count, n);
        end
        checks++;
        if (act_v !== seq[n]) begin
            errors++;
            $display("FAIL %s final act: got %h want %h", nm, act_v, seq[n]);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset async outputs: got %h want 0", all_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL reset idle outputs: got %h want 0", all_out);
            end
        end
    endtask

    task automatic test_single_pass();
        scr = {pk(5, 0, 0, 0)};
        run_comp(pk(9, 3, 2, 1), 0, "single_pass");
    endtask

    task automatic test_two_pass();
        scr = {pk(4, 2, 0, 1), pk(0, 0, 0, 7)};
        run_comp(pk(9, 3, 2, 1), 0, "two_pass");
    endtask

    task automatic test_all_suppressed();
        scr = {pk(0, 0, 0, 0)};
        run_comp(pk(-4, 3, 2, 8), 0, "suppressed");
    endtask

    task automatic test_timeout();
        scr = {pk(3, 3, 0, 0)};
        run_comp(pk(1, 2, 3, 4), 0, "timeout");
    endtask

    task automatic test_disturb();
        scr = {pk(4, 2, 0, 1), pk(0, 0, 0, 7)};
        run_comp(pk(9, 3, 2, 1), 3, "start_in_add");
        scr = {pk(0, 0, 6, 0)};
        run_comp(pk(1, 1, 1, 1), 1, "start_in_load");
        scr = {pk(1, 1, 0, 0)};
        pq = scr;
        @(negedge clk);
        init_v = pk(7, 8, 9, 10);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (ctl !== 6'b000010) begin
            errors++;
            $display("FAIL reset_mid RELU enables: got %b want 000010", ctl);
        end
        #2 rst = 1'b1;
        start = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_mid async outputs: got %h want 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL reset_mid idle outputs: got %h want 0", all_out);
            end
        end
        scr = {pk(0, 6, 0, 0)};
        run_comp(pk(0, 6, 0, 0), 0, "after_reset");
    endtask

    task automatic test_random();
        logic [127:0] init;
        int len;
        for (int t = 0; t < 12; t++) begin
            scr = {};
            len = int'($urandom_range(1, 4));
            for (int j = 0; j < len; j++)
                scr.push_back({rnd_val(), rnd_val(), rnd_val(), rnd_val()});
            init = {rnd_val(), rnd_val(), rnd_val(), rnd_val()};
            run_comp(init, ($urandom_range(0, 2) == 0) ? 3 : 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_two_pass();
        test_all_suppressed();
        test_timeout();
        test_disturb();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
